// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, replace-state enum and address helpers
// Address layout is {tag, index, offset}; all helpers slice a full physical address.
package dcache_pkg;

   localparam int ADDR_W   = 32;
   localparam int INDEX_W  = 6;
   localparam int WAY_W    = 3;
   localparam int OFFSET_W = 6;
   localparam int LINE_W   = 512;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PLRU,
      S_VICTIM,
      S_WB_REQ,
      S_WB_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_REFILL,
      S_DONE
   } replace_state_e;

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_replace.sv
// rtl/dcache_replace.sv - dcache miss-replacement controller
// One miss at a time: PLRU victim query, optional dirty writeback, refill, array write.
module dcache_replace
   import dcache_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                miss_valid,
   output logic                miss_ready,
   input  logic [ADDR_W-1:0]   miss_addr,
   output logic                replace2plru_valid,
   output logic [INDEX_W-1:0]  replace2plru_index,
   output logic                replace2plru_ready,
   input  logic [WAY_W-1:0]    plru2replace_way,
   output logic [INDEX_W-1:0]  meta_rd_index,
   output logic [WAY_W-1:0]    meta_rd_way,
   input  logic [TAG_W-1:0]    meta_rd_tag,
   input  logic                meta_rd_vld,
   input  logic                meta_rd_dirty,
   input  logic [LINE_W-1:0]   data_rd_line,
   output logic                mem_wr_valid,
   input  logic                mem_wr_ready,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [LINE_W-1:0]   mem_wr_data,
   input  logic                mem_wr_ack,
   output logic                mem_rd_valid,
   input  logic                mem_rd_ready,
   output logic [ADDR_W-1:0]   mem_rd_addr,
   input  logic                mem_rd_resp_valid,
   input  logic [LINE_W-1:0]   mem_rd_resp_data,
   output logic                refill_wr_valid,
   output logic [INDEX_W-1:0]  refill_wr_index,
   output logic [WAY_W-1:0]    refill_wr_way,
   output logic [TAG_W-1:0]    refill_wr_tag,
   output logic [LINE_W-1:0]   refill_wr_data,
   output logic                replace_done,
   output logic [WAY_W-1:0]    replace_done_way
);

   replace_state_e     state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WAY_W-1:0]   way_q;
   logic [ADDR_W-1:0]  wb_addr_q;
   logic [LINE_W-1:0]  wb_data_q;
   logic [LINE_W-1:0]  rd_data_q;
   logic               miss_ready_q;
   logic               plru_q;
   logic               wr_valid_q;
   logic               rd_valid_q;
   logic               refill_q;
   logic               done_q;

   // Strobes are registered alongside the state so each one mirrors exactly the state it belongs to.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         way_q        <= '0;
         wb_addr_q    <= '0;
         wb_data_q    <= '0;
         rd_data_q    <= '0;
         miss_ready_q <= 1'b1;
         plru_q       <= 1'b0;
         wr_valid_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         refill_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         plru_q   <= 1'b0;
         refill_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (miss_valid) begin
                  addr_q       <= miss_addr;
                  miss_ready_q <= 1'b0;
                  plru_q       <= 1'b1;
                  state_q      <= S_PLRU;
               end
            end
            S_PLRU: begin
               state_q <= S_VICTIM;
            end
            S_VICTIM: begin
               way_q     <= plru2replace_way;
               wb_addr_q <= {meta_rd_tag, addr_index(addr_q), {OFFSET_W{1'b0}}};
               wb_data_q <= data_rd_line;
               // An invalid line never writes back, whatever its dirty bit says.
               if (meta_rd_vld && meta_rd_dirty) begin
                  wr_valid_q <= 1'b1;
                  state_q    <= S_WB_REQ;
               end else begin
                  rd_valid_q <= 1'b1;
                  state_q    <= S_RD_REQ;
               end
            end
            S_WB_REQ: begin
               if (mem_wr_ready) begin
                  wr_valid_q <= 1'b0;
                  state_q    <= S_WB_WAIT;
               end
            end
            S_WB_WAIT: begin
               if (mem_wr_ack) begin
                  rd_valid_q <= 1'b1;
                  state_q    <= S_RD_REQ;
               end
            end
            S_RD_REQ: begin
               if (mem_rd_ready) begin
                  rd_valid_q <= 1'b0;
                  state_q    <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (mem_rd_resp_valid) begin
                  rd_data_q <= mem_rd_resp_data;
                  refill_q  <= 1'b1;
                  state_q   <= S_REFILL;
               end
            end
            S_REFILL: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               miss_ready_q <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: begin
               miss_ready_q <= 1'b1;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

   assign miss_ready         = miss_ready_q;
   assign replace2plru_valid = plru_q;
   assign replace2plru_ready = plru_q;
   assign replace2plru_index = addr_index(addr_q);

   // The PLRU way is only meaningful during VICTIM, which is when the arrays are sampled.
   assign meta_rd_index = addr_index(addr_q);
   assign meta_rd_way   = plru2replace_way;

   assign mem_wr_valid = wr_valid_q;
   assign mem_wr_addr  = wb_addr_q;
   assign mem_wr_data  = wb_data_q;
   assign mem_rd_valid = rd_valid_q;
   assign mem_rd_addr  = line_addr(addr_q);

   assign refill_wr_valid = refill_q;
   assign refill_wr_index = addr_index(addr_q);
   assign refill_wr_way   = way_q;
   assign refill_wr_tag   = addr_tag(addr_q);
   assign refill_wr_data  = rd_data_q;

   assign replace_done     = done_q;
   assign replace_done_way = way_q;

endmodule

// File: tb/tb_dcache_replace.sv
// tb/tb_dcache_replace.sv - randomized self-checking bench for dcache_replace
// Bench plays PLRU, tag/data arrays and memory; expectations come from address arithmetic.
module tb_dcache_replace;
   import dcache_pkg::*;

   localparam int CW = LINE_W;

   logic                clock;
   logic                reset;
   logic                miss_valid;
   logic                miss_ready;
   logic [ADDR_W-1:0]   miss_addr;
   logic                replace2plru_valid;
   logic [INDEX_W-1:0]  replace2plru_index;
   logic                replace2plru_ready;
   logic [WAY_W-1:0]    plru2replace_way;
   logic [INDEX_W-1:0]  meta_rd_index;
   logic [WAY_W-1:0]    meta_rd_way;
   logic [TAG_W-1:0]    meta_rd_tag;
   logic                meta_rd_vld;
   logic                meta_rd_dirty;
   logic [LINE_W-1:0]   data_rd_line;
   logic                mem_wr_valid;
   logic                mem_wr_ready;
   logic [ADDR_W-1:0]   mem_wr_addr;
   logic [LINE_W-1:0]   mem_wr_data;
   logic                mem_wr_ack;
   logic                mem_rd_valid;
   logic                mem_rd_ready;
   logic [ADDR_W-1:0]   mem_rd_addr;
   logic                mem_rd_resp_valid;
   logic [LINE_W-1:0]   mem_rd_resp_data;
   logic                refill_wr_valid;
   logic [INDEX_W-1:0]  refill_wr_index;
   logic [WAY_W-1:0]    refill_wr_way;
   logic [TAG_W-1:0]    refill_wr_tag;
   logic [LINE_W-1:0]   refill_wr_data;
   logic                replace_done;
   logic [WAY_W-1:0]    replace_done_way;

   int checks = 0;
   int errors = 0;

   logic [TAG_W-1:0]  tag_mem   [0:63][0:7];
   logic              vld_mem   [0:63][0:7];
   logic              dirty_mem [0:63][0:7];
   logic [LINE_W-1:0] line_mem  [0:63][0:7];

   dcache_replace dut (
      .clock              (clock),
      .reset              (reset),
      .miss_valid         (miss_valid),
      .miss_ready         (miss_ready),
      .miss_addr          (miss_addr),
      .replace2plru_valid (replace2plru_valid),
      .replace2plru_index (replace2plru_index),
      .replace2plru_ready (replace2plru_ready),
      .plru2replace_way   (plru2replace_way),
      .meta_rd_index      (meta_rd_index),
      .meta_rd_way        (meta_rd_way),
      .meta_rd_tag        (meta_rd_tag),
      .meta_rd_vld        (meta_rd_vld),
      .meta_rd_dirty      (meta_rd_dirty),
      .data_rd_line       (data_rd_line),
      .mem_wr_valid       (mem_wr_valid),
      .mem_wr_ready       (mem_wr_ready),
      .mem_wr_addr        (mem_wr_addr),
      .mem_wr_data        (mem_wr_data),
      .mem_wr_ack         (mem_wr_ack),
      .mem_rd_valid       (mem_rd_valid),
      .mem_rd_ready       (mem_rd_ready),
      .mem_rd_addr        (mem_rd_addr),
      .mem_rd_resp_valid  (mem_rd_resp_valid),
      .mem_rd_resp_data   (mem_rd_resp_data),
      .refill_wr_valid    (refill_wr_valid),
      .refill_wr_index    (refill_wr_index),
      .refill_wr_way      (refill_wr_way),
      .refill_wr_tag      (refill_wr_tag),
      .refill_wr_data     (refill_wr_data),
      .replace_done       (replace_done),
      .replace_done_way   (replace_done_way)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      meta_rd_tag   = tag_mem[meta_rd_index][meta_rd_way];
      meta_rd_vld   = vld_mem[meta_rd_index][meta_rd_way];
      meta_rd_dirty = dirty_mem[meta_rd_index][meta_rd_way];
      data_rd_line  = line_mem[meta_rd_index][meta_rd_way];
   end

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_reset_state();
      chk("rst_miss_ready", CW'(miss_ready), CW'(1));
      chk("rst_plru_valid", CW'(replace2plru_valid), CW'(0));
      chk("rst_plru_ready", CW'(replace2plru_ready), CW'(0));
      chk("rst_wr_valid", CW'(mem_wr_valid), CW'(0));
      chk("rst_rd_valid", CW'(mem_rd_valid), CW'(0));
      chk("rst_refill", CW'(refill_wr_valid), CW'(0));
      chk("rst_done", CW'(replace_done), CW'(0));
      chk("rst_done_way", CW'(replace_done_way), CW'(0));
      chk("rst_wr_addr", CW'(mem_wr_addr), CW'(0));
      chk("rst_rd_addr", CW'(mem_rd_addr), CW'(0));
      chk("rst_refill_data", refill_wr_data, CW'(0));
   endtask

   // Entered and left at a negedge; the miss is presented immediately on entry.
   task automatic run_miss(input logic [ADDR_W-1:0] a, input logic [WAY_W-1:0] w,
         input logic [TAG_W-1:0] vtag, input bit vld, input bit dty,
         input int wr_stall, input int wb_lat, input int rd_stall, input int rd_lat,
         input bit stray, input bit abort);
      logic [INDEX_W-1:0] idx;
      logic [LINE_W-1:0]  vline, nline;
      logic [ADDR_W-1:0]  exp_wb, exp_rd;
      bit do_wb, plru_prev, wr_hs, wb_wait, wb_done, wr_acc, rd_hs, rd_wait, rd_acc, done_seen;
      int exp_lat, n, refill_cnt, wr_cnt, rd_cnt, wait_cnt;
      idx   = INDEX_W'(a >> OFFSET_W);
      vline = rand_line();
      nline = rand_line();
      tag_mem[idx][w]   = vtag;
      vld_mem[idx][w]   = vld;
      dirty_mem[idx][w] = dty;
      line_mem[idx][w]  = vline;
      do_wb   = vld && dty;
      exp_wb  = (ADDR_W'(vtag) << (INDEX_W + OFFSET_W)) | (a & 32'h0000_0FC0);
      exp_rd  = a & 32'hFFFF_FFC0;
      exp_lat = 6 + rd_stall + rd_lat + (do_wb ? 2 + wr_stall + wb_lat : 0);
      {plru_prev, wr_hs, wb_wait, wb_done, wr_acc, rd_hs, rd_wait, rd_acc, done_seen} = '0;
      n = 0; refill_cnt = 0; wr_cnt = 0; rd_cnt = 0; wait_cnt = 0;

      chk("accept_ready", CW'(miss_ready), CW'(1));
      miss_valid        = 1'b1;
      miss_addr         = a;
      plru2replace_way  = 3'($urandom);
      mem_wr_ack        = 1'b0;
      mem_rd_resp_valid = 1'b0;

      while (!done_seen && n < 300) begin
         @(negedge clock);
         n++;
         chk("plru_valid", CW'(replace2plru_valid), CW'(n == 1));
         chk("plru_ready", CW'(replace2plru_ready), CW'(n == 1));
         if (n == 1) chk("plru_index", CW'(replace2plru_index), CW'(idx));
         chk("busy_ready", CW'(miss_ready), CW'(0));
         if (mem_wr_valid) begin
            chk("wr_expected", CW'(do_wb && !wr_acc), CW'(1));
            chk("wr_addr", CW'(mem_wr_addr), CW'(exp_wb));
            chk("wr_data", mem_wr_data, vline);
         end
         if (mem_rd_valid) begin
            chk("rd_after_wb", CW'(!do_wb || wb_done), CW'(1));
            chk("rd_expected", CW'(!rd_acc), CW'(1));
            chk("rd_addr", CW'(mem_rd_addr), CW'(exp_rd));
         end
         if (refill_wr_valid) begin
            refill_cnt++;
            chk("refill_cycle", CW'(n), CW'(exp_lat - 1));
            chk("refill_index", CW'(refill_wr_index), CW'(idx));
            chk("refill_way", CW'(refill_wr_way), CW'(w));
            chk("refill_tag", CW'(refill_wr_tag), CW'(a >> (INDEX_W + OFFSET_W)));
            chk("refill_data", refill_wr_data, nline);
         end
         if (replace_done) begin
            done_seen = 1'b1;
            chk("done_latency", CW'(n), CW'(exp_lat));
            chk("done_way", CW'(replace_done_way), CW'(w));
         end

         // A miss offered while busy (including in DONE) must be ignored.
         miss_valid        = replace_done ? 1'b1 : 1'($urandom_range(0, 1));
         miss_addr         = $urandom;
         plru2replace_way  = plru_prev ? w : 3'($urandom);
         plru_prev         = replace2plru_valid;
         mem_wr_ready      = 1'($urandom_range(0, 1));
         mem_rd_ready      = 1'($urandom_range(0, 1));
         mem_wr_ack        = stray ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rd_resp_valid = stray ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rd_resp_data  = rand_line();

         if (wr_hs) begin wr_hs = 1'b0; wb_wait = 1'b1; wait_cnt = 0; end
         if (wb_wait) begin
            mem_wr_ack = 1'b0;
            if (wait_cnt == wb_lat) begin
               mem_wr_ack = 1'b1; wb_wait = 1'b0; wb_done = 1'b1;
            end else wait_cnt++;
         end
         if (rd_hs) begin rd_hs = 1'b0; rd_wait = 1'b1; wait_cnt = 0; end
         if (rd_wait) begin
            mem_rd_resp_valid = 1'b0;
            if (abort) begin
               reset = 1'b1; miss_valid = 1'b0; mem_wr_ack = 1'b0;
               @(negedge clock);
               reset = 1'b0;
               check_reset_state();
               mem_rd_resp_valid = 1'b1;
               mem_rd_resp_data  = rand_line();
               @(negedge clock);
               mem_rd_resp_valid = 1'b0;
               chk("late_resp_refill", CW'(refill_wr_valid), CW'(0));
               chk("late_resp_ready", CW'(miss_ready), CW'(1));
               return;
            end
            if (wait_cnt == rd_lat) begin
               mem_rd_resp_valid = 1'b1; mem_rd_resp_data = nline; rd_wait = 1'b0;
            end else wait_cnt++;
         end
         if (mem_wr_valid) begin
            mem_wr_ready = (wr_cnt >= wr_stall);
            wr_cnt++;
            if (mem_wr_ready) begin wr_hs = 1'b1; wr_acc = 1'b1; end
         end
         if (mem_rd_valid) begin
            mem_rd_ready = (rd_cnt >= rd_stall);
            rd_cnt++;
            if (mem_rd_ready) begin rd_hs = 1'b1; rd_acc = 1'b1; end
         end
      end

      if (!done_seen) chk("done_timeout", CW'(0), CW'(1));
      chk("refill_count", CW'(refill_cnt), CW'(1));
      chk("writeback_done", CW'(wr_acc), CW'(do_wb));
      @(negedge clock);
      miss_valid = 1'b0; mem_wr_ack = 1'b0; mem_rd_resp_valid = 1'b0;
      chk("idle_ready", CW'(miss_ready), CW'(1));
      chk("done_single", CW'(replace_done), CW'(0));
      chk("done_way_hold", CW'(replace_done_way), CW'(w));
   endtask

   initial begin
      reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; plru2replace_way = '0;
      mem_wr_ready = 1'b0; mem_wr_ack = 1'b0; mem_rd_ready = 1'b0;
      mem_rd_resp_valid = 1'b0; mem_rd_resp_data = '0;
      repeat (3) @(negedge clock);
      check_reset_state();
      reset = 1'b0;
      @(negedge clock);

      // clean victim, then dirty victim, then backpressure on both channels
      run_miss(32'h0001_2340, 3'd3, 20'h12345, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      run_miss(32'h0001_2340, 3'd3, 20'hABCDE, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0);
      run_miss(32'h0001_2340, 3'd3, 20'hABCDE, 1'b1, 1'b1, 5, 0, 5, 0, 1'b0, 1'b0);

      // stray responses while idle, then during WB_WAIT and around RD_WAIT
      for (int i = 0; i < 4; i++) begin
         mem_rd_resp_valid = 1'b1; mem_wr_ack = 1'b1; mem_wr_ready = 1'b1; mem_rd_ready = 1'b1;
         @(negedge clock);
         chk("idle_stray_refill", CW'(refill_wr_valid), CW'(0));
         chk("idle_stray_wr", CW'(mem_wr_valid), CW'(0));
         chk("idle_stray_rd", CW'(mem_rd_valid), CW'(0));
         chk("idle_stray_ready", CW'(miss_ready), CW'(1));
      end
      mem_rd_resp_valid = 1'b0; mem_wr_ack = 1'b0;
      run_miss(32'h8765_4321, 3'd6, 20'h5A5A5, 1'b1, 1'b1, 1, 3, 1, 3, 1'b1, 1'b0);

      // invalid but dirty victim must not write back
      run_miss(32'h0000_0FC0, 3'd0, 20'hFFFFF, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0);

      // back-to-back misses
      run_miss(32'h1111_1040, 3'd1, 20'h00001, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      run_miss(32'h2222_2080, 3'd7, 20'h00002, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0);

      // reset while waiting for refill data, then a normal miss
      run_miss(32'h3333_30C0, 3'd5, 20'h77777, 1'b1, 1'b1, 0, 1, 0, 2, 1'b0, 1'b1);
      run_miss(32'h4444_4100, 3'd2, 20'h88888, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_miss($urandom, 3'($urandom_range(0, 7)), TAG_W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
